// File: rtl/riscv_if_prefetch.sv
// riscv_if_prefetch: sequential instruction fetch over APB into a small
// prefetch queue. Each queue entry carries the instruction, its PC and the
// bus error flag. A redirect flushes the queue and restarts fetch; a transfer
// already on the bus when the redirect arrives finishes there but its data is
// thrown away.
module riscv_if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i,
  output logic              if_dec_valid_o,
  output logic [DATA_W-1:0] if_dec_instr_o,
  output logic [ADDR_W-1:0] if_dec_pc_o,
  output logic              if_dec_err_o,
  input  logic              dec_if_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]        state_r, state_next_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_next_s;
  logic [ADDR_W-1:0] paddr_r, paddr_next_s;
  logic              halted_r, halted_next_s;
  logic              stale_r, stale_next_s;
  logic              valid_r;
  logic [PTR_W:0]    count_r, count_next_s;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;

  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic              err_mem_r   [DEPTH];

  logic              complete_s, good_done_s, push_s, pop_s, issue_s;
  logic [ADDR_W-1:0] redirect_pc_aligned_s;

  assign redirect_pc_aligned_s = redirect_pc_i & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  assign complete_s  = (state_r == ST_ACCESS) && pready_i;
  // A completion that belongs to the current fetch stream (not flushed).
  assign good_done_s = complete_s && !stale_r && !redirect_i;
  assign push_s      = good_done_s;
  assign pop_s       = valid_r && dec_if_ready_i && !redirect_i;

  // Queue occupancy, halt/stale flags and fetch PC for the next cycle.
  always_comb begin
    count_next_s    = count_r;
    halted_next_s   = halted_r;
    stale_next_s    = stale_r;
    fetch_pc_next_s = fetch_pc_r;
    if (redirect_i) begin
      count_next_s    = {(PTR_W+1){1'b0}};
      halted_next_s   = 1'b0;
      stale_next_s    = (state_r == ST_SETUP) || ((state_r == ST_ACCESS) && !pready_i);
      fetch_pc_next_s = redirect_pc_aligned_s;
    end else begin
      count_next_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
      if (complete_s) begin
        stale_next_s = 1'b0;
      end else begin
        stale_next_s = stale_r;
      end
      if (good_done_s && pslverr_i) begin
        halted_next_s = 1'b1;
      end else if (good_done_s) begin
        fetch_pc_next_s = fetch_pc_r + PC_STEP;
      end else begin
        halted_next_s = halted_r;
      end
    end
  end

  // Back-to-back issue is allowed only if space remains after this cycle's push/pop.
  assign issue_s = (count_next_s < DEPTH_C) && !halted_next_s;

  // APB transfer sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect_i || ((count_r < DEPTH_C) && !halted_r)) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: state_next_s = ST_ACCESS;
      ST_ACCESS: begin
        if (!pready_i) begin
          state_next_s = ST_ACCESS;
        end else if (redirect_i || issue_s) begin
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Bus address is frozen while a transfer is on the bus, even across a redirect.
  always_comb begin
    if (state_next_s == ST_ACCESS) begin
      paddr_next_s = paddr_r;
    end else begin
      paddr_next_s = fetch_pc_next_s;
    end
  end

  // Control state, pointers and flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      paddr_r    <= RESET_PC;
      halted_r   <= 1'b0;
      stale_r    <= 1'b0;
      valid_r    <= 1'b0;
      count_r    <= {(PTR_W+1){1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      paddr_r    <= paddr_next_s;
      halted_r   <= halted_next_s;
      stale_r    <= stale_next_s;
      valid_r    <= (count_next_s != {(PTR_W+1){1'b0}});
      count_r    <= count_next_s;
      if (redirect_i) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Queue storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= prdata_i;
      pc_mem_r[wr_ptr_r]    <= paddr_r;
      err_mem_r[wr_ptr_r]   <= pslverr_i;
    end
  end

  // Head of queue toward decode, forced to zero when empty.
  always_comb begin
    if (valid_r) begin
      if_dec_instr_o = instr_mem_r[rd_ptr_r];
      if_dec_pc_o    = pc_mem_r[rd_ptr_r];
      if_dec_err_o   = err_mem_r[rd_ptr_r];
    end else begin
      if_dec_instr_o = {DATA_W{1'b0}};
      if_dec_pc_o    = {ADDR_W{1'b0}};
      if_dec_err_o   = 1'b0;
    end
  end

  assign if_dec_valid_o = valid_r;
  assign psel_o         = (state_r != ST_IDLE);
  assign penable_o      = (state_r == ST_ACCESS);
  assign paddr_o        = paddr_r;
  assign pwrite_o       = 1'b0;
  assign pwdata_o       = {DATA_W{1'b0}};

endmodule
